// File: rtl/pmem_loadable.sv
// Run-time loadable program memory: synchronous RAM plus per-word valid bits, filled by a
// valid/ready load port or swept back to JMP 0; word 0 is hard-wired to the idle loop.
module pmem_loadable #(
  parameter int              AW            = 13,
  parameter int              DW            = 18,
  parameter int              DEPTH         = 1024,
  parameter logic [DW-1:0]   IDLE_INSTR    = 'h30000,
  parameter logic [DW-1:0]   DEFAULT_INSTR = 'h34000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] padr,
  input  logic          pen,
  output logic [DW-1:0] dout,
  input  logic          clr,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          busy,
  output logic          ld_err
);

  localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CLEAR} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_ptr;
  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DW-1:0]    r_dout;
  logic             r_ld_err;

  logic             w_accept;
  logic             w_ptr_ok;
  logic             w_padr_ok;
  logic             w_we;
  logic [DW-1:0]    w_wdata;
  logic [IW-1:0]    w_widx;
  logic [IW-1:0]    w_ridx;

  assign ld_ready  = (r_state == S_LOAD);
  assign busy      = (r_state != S_IDLE);
  assign dout      = r_dout;
  assign ld_err    = r_ld_err;

  assign w_accept  = ld_ready & ld_valid;
  // Word 0 is never writable so the idle loop survives any load.
  assign w_ptr_ok  = ({1'b0, r_ptr} < DEPTH_W) && (r_ptr != '0);
  assign w_padr_ok = ({1'b0, padr} < DEPTH_W);
  assign w_widx    = r_ptr[IW-1:0];
  assign w_ridx    = padr[IW-1:0];

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_we    = 1'b0;
    w_wdata = DEFAULT_INSTR;
    if (r_state == S_LOAD && w_accept && w_ptr_ok) begin
      w_we    = 1'b1;
      w_wdata = ld_data;
    end else if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
    end
  end

  // NOTE: the RAM array has no reset; the valid vector alone decides what is readable after reset.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_widx] <= w_wdata;
  end

  // NOTE: non-blocking assignments here make a same-edge fetch see the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_valid  <= '0;
      r_ld_err <= 1'b0;
      r_dout   <= IDLE_INSTR;
    end else begin
      if (w_we) r_valid[w_widx] <= (r_state == S_LOAD);

      case (r_state)
        S_IDLE: begin
          if (clr) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
          end else if (ld_start) begin
            r_state  <= S_LOAD;
            r_ptr    <= ld_base;
            r_ld_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_ptr <= r_ptr + 1'b1;
            if (!w_ptr_ok) r_ld_err <= 1'b1;
            if (ld_last)   r_state  <= S_IDLE;
          end
        end
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == LAST_PTR) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (pen) begin
        if (padr == '0)
          r_dout <= IDLE_INSTR;
        else if (busy || !w_padr_ok || !r_valid[w_ridx])
          r_dout <= DEFAULT_INSTR;
        else
          r_dout <= r_mem[w_ridx];
      end
    end
  end

endmodule
